// File: rtl/tsoip_rx_deframer.sv
// Receive-side TSoIP deframer: filters one Ethernet/IPv4/UDP frame on its header fields,
// strips the 42-byte header and forwards the TS payload packets with a 1-cycle registered latency.
module tsoip_rx_deframer #(
  parameter bit          BROADCAST_EN = 1'b1,
  parameter logic [15:0] ETHERTYPE    = 16'h0800,
  parameter logic [7:0]  TS_SYNC_BYTE = 8'h47,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  input  logic             i_Sync,
  input  logic             i_End,
  input  logic [7:0]       i_Data,
  input  logic [47:0]      i_MacLocal,
  input  logic [31:0]      i_IpLocal,
  input  logic [7:0]       i_Protocol,
  input  logic [15:0]      i_PortDest,
  input  logic [7:0]       i_PacketLength,
  input  logic [2:0]       i_NumberPacket,
  output logic             o_ts_valid,
  output logic             o_ts_sync,
  output logic [7:0]       o_ts_data,
  output logic             o_FrameOk,
  output logic             o_FrameDrop,
  output logic [2:0]       o_DropCause,
  output logic [CNT_W-1:0] o_FrameCount,
  output logic [CNT_W-1:0] o_DropCount
);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StTail, StDiscard} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic               fld_ok_q, fld_ok_d;
  logic               bcast_q, bcast_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [2:0]         pkt_q, pkt_d;
  logic [47:0]        mac_q, mac_d;
  logic [31:0]        ip_q, ip_d;
  logic [7:0]         proto_q, proto_d;
  logic [15:0]        port_q, port_d;
  logic [7:0]         len_q, len_d;
  logic [2:0]         num_q, num_d;
  logic               ts_valid_q, ts_valid_d;
  logic               ts_sync_q, ts_sync_d;
  logic [7:0]         ts_data_q, ts_data_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_drop_q, frame_drop_d;
  logic [2:0]         drop_cause_q, drop_cause_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic        start;
  logic [5:0]  idx;
  logic [47:0] mac_cfg;
  logic [7:0]  exp_byte;
  logic        byte_eq, field_first, acc, bc_acc;
  logic        hdr_fail;
  logic [2:0]  hdr_cause;
  logic        pay_last;

  // A sync byte always opens a new frame at index 0, whatever state we are in.
  assign start   = i_Valid & i_Sync;
  assign idx     = start ? 6'd0 : idx_q;
  // Config is latched at byte 0, so byte 0 itself must compare against the live port.
  assign mac_cfg = start ? i_MacLocal : mac_q;

  always_comb begin
    exp_byte = 8'h00;
    case (idx)
      6'd0:    exp_byte = mac_cfg[47:40];
      6'd1:    exp_byte = mac_cfg[39:32];
      6'd2:    exp_byte = mac_cfg[31:24];
      6'd3:    exp_byte = mac_cfg[23:16];
      6'd4:    exp_byte = mac_cfg[15:8];
      6'd5:    exp_byte = mac_cfg[7:0];
      6'd12:   exp_byte = ETHERTYPE[15:8];
      6'd13:   exp_byte = ETHERTYPE[7:0];
      6'd14:   exp_byte = 8'h45;
      6'd23:   exp_byte = proto_q;
      6'd30:   exp_byte = ip_q[31:24];
      6'd31:   exp_byte = ip_q[23:16];
      6'd32:   exp_byte = ip_q[15:8];
      6'd33:   exp_byte = ip_q[7:0];
      6'd36:   exp_byte = port_q[15:8];
      6'd37:   exp_byte = port_q[7:0];
      default: exp_byte = 8'h00;
    endcase
  end

  always_comb begin
    byte_eq     = (i_Data == exp_byte);
    field_first = (idx == 6'd0) || (idx == 6'd12) || (idx == 6'd23) ||
                  (idx == 6'd30) || (idx == 6'd36);
    acc         = field_first ? byte_eq : (fld_ok_q & byte_eq);
    bc_acc      = ((idx == 6'd0) ? 1'b1 : bcast_q) & (i_Data == 8'hFF);
    hdr_fail    = 1'b0;
    hdr_cause   = 3'd0;
    case (idx)
      6'd5: if (!(acc || (BROADCAST_EN && bc_acc))) begin
        hdr_fail  = 1'b1;
        hdr_cause = 3'd1;
      end
      6'd13, 6'd14: if (!((idx == 6'd13) ? acc : byte_eq)) begin
        hdr_fail  = 1'b1;
        hdr_cause = 3'd2;
      end
      6'd23: if (!acc) begin
        hdr_fail  = 1'b1;
        hdr_cause = 3'd3;
      end
      6'd33: if (!acc) begin
        hdr_fail  = 1'b1;
        hdr_cause = 3'd4;
      end
      6'd37: if (!acc || (num_q == 3'd0)) begin
        hdr_fail  = 1'b1;
        hdr_cause = 3'd5;
      end
      default: ;
    endcase
  end

  assign pay_last = (byte_cnt_q == len_q - 8'd1) && (pkt_q == num_q - 3'd1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fld_ok_d     = fld_ok_q;
    bcast_d      = bcast_q;
    byte_cnt_d   = byte_cnt_q;
    pkt_d        = pkt_q;
    mac_d        = mac_q;
    ip_d         = ip_q;
    proto_d      = proto_q;
    port_d       = port_q;
    len_d        = len_q;
    num_d        = num_q;
    ts_valid_d   = 1'b0;
    ts_sync_d    = 1'b0;
    ts_data_d    = 8'h00;
    frame_ok_d   = 1'b0;
    frame_drop_d = 1'b0;
    drop_cause_d = drop_cause_q;
    if (start) begin
      // Close the frame in flight before taking this byte as byte 0 of the next one.
      if (state_q == StTail) frame_ok_d = 1'b1;
      if (state_q == StHdr || state_q == StPay) begin
        frame_drop_d = 1'b1;
        drop_cause_d = 3'd7;
      end
      mac_d    = i_MacLocal;
      ip_d     = i_IpLocal;
      proto_d  = i_Protocol;
      port_d   = i_PortDest;
      len_d    = i_PacketLength;
      num_d    = i_NumberPacket;
      fld_ok_d = acc;
      bcast_d  = bc_acc;
      if (i_End) begin
        frame_drop_d = 1'b1;
        drop_cause_d = 3'd7;
        state_d      = StIdle;
      end else begin
        state_d = StHdr;
        idx_d   = 6'd1;
      end
    end else if (i_Valid) begin
      unique case (state_q)
        StHdr: begin
          fld_ok_d = acc;
          bcast_d  = bc_acc;
          if (hdr_fail) begin
            frame_drop_d = 1'b1;
            drop_cause_d = hdr_cause;
            state_d      = i_End ? StIdle : StDiscard;
          end else if (i_End) begin
            frame_drop_d = 1'b1;
            drop_cause_d = 3'd7;
            state_d      = StIdle;
          end else if (idx_q == 6'd41) begin
            state_d    = StPay;
            byte_cnt_d = 8'd0;
            pkt_d      = 3'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        StPay: begin
          if (i_End && !pay_last) begin
            frame_drop_d = 1'b1;
            drop_cause_d = 3'd7;
            state_d      = StIdle;
          end else if ((byte_cnt_q == 8'd0) && (i_Data != TS_SYNC_BYTE)) begin
            frame_drop_d = 1'b1;
            drop_cause_d = 3'd6;
            state_d      = i_End ? StIdle : StDiscard;
          end else begin
            ts_valid_d = 1'b1;
            ts_sync_d  = (byte_cnt_q == 8'd0);
            ts_data_d  = i_Data;
            if (pay_last) begin
              if (i_End) begin
                frame_ok_d = 1'b1;
                state_d    = StIdle;
              end else begin
                state_d = StTail;
              end
            end else if (byte_cnt_q == len_q - 8'd1) begin
              byte_cnt_d = 8'd0;
              pkt_d      = pkt_q + 3'd1;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        StTail: begin
          if (i_End) begin
            frame_ok_d = 1'b1;
            state_d    = StIdle;
          end
        end
        StDiscard: begin
          if (i_End) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (frame_ok_d && (frame_cnt_q != {CNT_W{1'b1}})) frame_cnt_d = frame_cnt_q + 1'b1;
    if (frame_drop_d && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      idx_q        <= 6'd0;
      fld_ok_q     <= 1'b0;
      bcast_q      <= 1'b0;
      byte_cnt_q   <= 8'd0;
      pkt_q        <= 3'd0;
      mac_q        <= 48'd0;
      ip_q         <= 32'd0;
      proto_q      <= 8'd0;
      port_q       <= 16'd0;
      len_q        <= 8'd0;
      num_q        <= 3'd0;
      ts_valid_q   <= 1'b0;
      ts_sync_q    <= 1'b0;
      ts_data_q    <= 8'h00;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_cause_q <= 3'd0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fld_ok_q     <= fld_ok_d;
      bcast_q      <= bcast_d;
      byte_cnt_q   <= byte_cnt_d;
      pkt_q        <= pkt_d;
      mac_q        <= mac_d;
      ip_q         <= ip_d;
      proto_q      <= proto_d;
      port_q       <= port_d;
      len_q        <= len_d;
      num_q        <= num_d;
      ts_valid_q   <= ts_valid_d;
      ts_sync_q    <= ts_sync_d;
      ts_data_q    <= ts_data_d;
      frame_ok_q   <= frame_ok_d;
      frame_drop_q <= frame_drop_d;
      drop_cause_q <= drop_cause_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign o_ts_valid   = ts_valid_q;
  assign o_ts_sync    = ts_sync_q;
  assign o_ts_data    = ts_data_q;
  assign o_FrameOk    = frame_ok_q;
  assign o_FrameDrop  = frame_drop_q;
  assign o_DropCause  = drop_cause_q;
  assign o_FrameCount = frame_cnt_q;
  assign o_DropCount  = drop_cnt_q;

endmodule

// File: tb/tb_tsoip_rx_deframer.sv
// Scoreboard bench for tsoip_rx_deframer: frames are built byte by byte, expected TS bytes are
// queued as they are driven and popped when the deframer emits them.
module tb_tsoip_rx_deframer;

  localparam logic [47:0] MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] IP   = 32'hC0A8_0A01;
  localparam logic [15:0] PORT = 16'd1234;
  localparam int          LEN  = 188;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Valid, i_Sync, i_End;
  logic [7:0]  i_Data;
  logic [47:0] i_MacLocal;
  logic [31:0] i_IpLocal;
  logic [7:0]  i_Protocol;
  logic [15:0] i_PortDest;
  logic [7:0]  i_PacketLength;
  logic [2:0]  i_NumberPacket;
  logic        o_ts_valid, o_ts_sync, o_FrameOk, o_FrameDrop;
  logic [7:0]  o_ts_data;
  logic [2:0]  o_DropCause;
  logic [15:0] o_FrameCount, o_DropCount;

  int n_vec = 0;
  int n_err = 0;
  int n_ts, n_sync, ok_seen, drop_seen, ok_idx, drop_idx;
  int cur_idx = -1;
  logic [8:0] exp_q[$];
  logic [7:0] frm[$];

  tsoip_rx_deframer dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Valid        (i_Valid),
    .i_Sync         (i_Sync),
    .i_End          (i_End),
    .i_Data         (i_Data),
    .i_MacLocal     (i_MacLocal),
    .i_IpLocal      (i_IpLocal),
    .i_Protocol     (i_Protocol),
    .i_PortDest     (i_PortDest),
    .i_PacketLength (i_PacketLength),
    .i_NumberPacket (i_NumberPacket),
    .o_ts_valid     (o_ts_valid),
    .o_ts_sync      (o_ts_sync),
    .o_ts_data      (o_ts_data),
    .o_FrameOk      (o_FrameOk),
    .o_FrameDrop    (o_FrameDrop),
    .o_DropCause    (o_DropCause),
    .o_FrameCount   (o_FrameCount),
    .o_DropCount    (o_DropCount)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    n_ts = 0; n_sync = 0; ok_seen = 0; drop_seen = 0; ok_idx = -1; drop_idx = -1;
  endtask

  // Outputs at posedge+1 belong to the byte that was on the inputs at that posedge.
  task automatic monitor();
    int         idx_snap;
    logic       v_snap;
    logic [8:0] exp;
    forever begin
      @(posedge clk);
      idx_snap = cur_idx;
      v_snap   = i_Valid;
      #1;
      if (o_ts_valid === 1'b1) begin
        n_ts++;
        if (o_ts_sync === 1'b1) n_sync++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ts_unexpected: got sync %b data %h, want no output", o_ts_sync, o_ts_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_ts_sync, o_ts_data} !== exp) begin
            n_err++;
            $display("FAIL ts_byte: got sync %b data %h, want sync %b data %h",
                     o_ts_sync, o_ts_data, exp[8], exp[7:0]);
          end
        end
        n_vec++;
        if (v_snap !== 1'b1) begin
          n_err++;
          $display("FAIL ts_gap: ts_valid with input valid %b, want 1", v_snap);
        end
      end else if (!rst) begin
        n_vec++;
        if ({o_ts_sync, o_ts_data} !== 9'd0) begin
          n_err++;
          $display("FAIL ts_idle: got sync %b data %h, want 0 0", o_ts_sync, o_ts_data);
        end
      end
      if (o_FrameOk === 1'b1) begin ok_seen++; ok_idx = idx_snap; end
      if (o_FrameDrop === 1'b1) begin drop_seen++; drop_idx = idx_snap; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; i_Valid = 1'b0; i_Sync = 1'b0; i_End = 1'b0; i_Data = 8'h00; cur_idx = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d,
                       input int idx);
    @(negedge clk);
    i_Valid = v; i_Sync = s; i_End = e; i_Data = d; cur_idx = idx;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic build_frame(input logic [47:0] mac, input logic [15:0] port, input int bad_pkt,
                             input int n_pay, input int n_fcs);
    logic [7:0] h[42];
    for (int k = 0; k < 42; k++) h[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) h[k] = mac[47-8*k -: 8];
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[23] = 8'd17;
    for (int k = 0; k < 4; k++) h[30+k] = IP[31-8*k -: 8];
    h[36] = port[15:8]; h[37] = port[7:0];
    frm.delete();
    for (int k = 0; k < 42; k++) frm.push_back(h[k]);
    for (int p = 0; p < n_pay; p++) begin
      if (p % LEN == 0) frm.push_back((p / LEN == bad_pkt) ? 8'h48 : 8'h47);
      else frm.push_back(8'($urandom));
    end
    for (int k = 0; k < n_fcs; k++) frm.push_back(8'($urandom));
  endtask

  // Drives the first n_drive bytes (all if negative); payload bytes below out_lim are expected out.
  task automatic send_frame(input int out_lim, input bit gaps, input int n_drive);
    int n;
    n = (n_drive < 0) ? frm.size() : n_drive;
    for (int k = 0; k < n; k++) begin
      if (gaps) drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), -1);
      drive(1'b1, k == 0, k == frm.size() - 1, frm[k], k);
      if (k >= 42 && (k - 42) < out_lim) exp_q.push_back({((k - 42) % LEN) == 0, frm[k]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_Valid = 1'b0; i_Sync = 1'b0; i_End = 1'b0; i_Data = 8'h00;
    i_MacLocal = MAC; i_IpLocal = IP; i_Protocol = 8'd17; i_PortDest = PORT;
    i_PacketLength = 8'(LEN); i_NumberPacket = 3'd7;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_ts_valid, o_ts_sync, o_ts_data, o_FrameOk, o_FrameDrop, o_DropCause} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b %b %h %b %b %0d, want all 0", o_ts_valid, o_ts_sync,
               o_ts_data, o_FrameOk, o_FrameDrop, o_DropCause);
    end
    n_vec++;
    if ({o_FrameCount, o_DropCount} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counts: got %0d %0d, want 0 0", o_FrameCount, o_DropCount);
    end
    apply_reset();
  endtask

  task automatic test_good_frame();
    apply_reset();
    build_frame(MAC, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b0, -1);
    idle(3);
    n_vec++;
    if (n_ts !== 1316) begin n_err++; $display("FAIL good_ts_count: got %0d, want 1316", n_ts); end
    n_vec++;
    if (n_sync !== 7) begin n_err++; $display("FAIL good_sync_count: got %0d, want 7", n_sync); end
    n_vec++;
    if (ok_seen !== 1 || ok_idx !== 1361) begin
      n_err++;
      $display("FAIL good_frame_ok: got %0d pulses at byte %0d, want 1 at 1361", ok_seen, ok_idx);
    end
    n_vec++;
    if (o_FrameCount !== 16'd1 || drop_seen !== 0) begin
      n_err++;
      $display("FAIL good_counts: got frames %0d drops %0d, want 1 0", o_FrameCount, drop_seen);
    end
  endtask

  task automatic test_bad_mac();
    apply_reset();
    build_frame(MAC ^ 48'h1, PORT, -1, 7 * LEN, 4);
    send_frame(0, 1'b0, -1);
    idle(3);
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 5 || o_DropCause !== 3'd1 || n_ts !== 0) begin
      n_err++;
      $display("FAIL mac_drop: got %0d drops at byte %0d cause %0d ts %0d, want 1 at 5 cause 1 ts 0",
               drop_seen, drop_idx, o_DropCause, n_ts);
    end
    clear_stats();
    build_frame(48'hFFFF_FFFF_FFFF, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b0, -1);
    idle(3);
    n_vec++;
    if (ok_seen !== 1 || n_ts !== 1316 || o_FrameCount !== 16'd1 || o_DropCount !== 16'd1) begin
      n_err++;
      $display("FAIL mac_bcast: got ok %0d ts %0d frames %0d drops %0d, want 1 1316 1 1",
               ok_seen, n_ts, o_FrameCount, o_DropCount);
    end
  endtask

  task automatic test_bad_port();
    apply_reset();
    build_frame(MAC, 16'd1235, -1, 7 * LEN, 4);
    send_frame(0, 1'b0, -1);
    idle(3);
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 37 || o_DropCause !== 3'd5 || o_DropCount !== 16'd1) begin
      n_err++;
      $display("FAIL port_drop: got %0d drops at byte %0d cause %0d count %0d, want 1 37 5 1",
               drop_seen, drop_idx, o_DropCause, o_DropCount);
    end
    clear_stats();
    i_NumberPacket = 3'd0;
    build_frame(MAC, PORT, -1, 20, 0);
    send_frame(0, 1'b0, -1);
    idle(3);
    i_NumberPacket = 3'd7;
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 37 || o_DropCause !== 3'd5 || o_DropCount !== 16'd2) begin
      n_err++;
      $display("FAIL npkt_zero: got %0d drops at byte %0d cause %0d count %0d, want 1 37 5 2",
               drop_seen, drop_idx, o_DropCause, o_DropCount);
    end
  endtask

  task automatic test_bad_sync();
    apply_reset();
    build_frame(MAC, PORT, 2, 7 * LEN, 4);
    send_frame(2 * LEN, 1'b0, -1);
    idle(3);
    n_vec++;
    if (n_ts !== 376 || n_sync !== 2) begin
      n_err++;
      $display("FAIL sync_ts: got %0d bytes %0d syncs, want 376 2", n_ts, n_sync);
    end
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 418 || o_DropCause !== 3'd6 || ok_seen !== 0) begin
      n_err++;
      $display("FAIL sync_drop: got %0d drops at byte %0d cause %0d ok %0d, want 1 418 6 0",
               drop_seen, drop_idx, o_DropCause, ok_seen);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    build_frame(MAC, PORT, -1, 101, 0);
    send_frame(100, 1'b0, -1);
    build_frame(MAC, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b0, -1);
    idle(3);
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 142 || o_DropCause !== 3'd7) begin
      n_err++;
      $display("FAIL trunc_drop: got %0d drops at byte %0d cause %0d, want 1 142 7",
               drop_seen, drop_idx, o_DropCause);
    end
    n_vec++;
    if (n_ts !== 1416 || ok_seen !== 1 || ok_idx !== 1361 || o_FrameCount !== 16'd1) begin
      n_err++;
      $display("FAIL trunc_next: got ts %0d ok %0d at %0d frames %0d, want 1416 1 1361 1",
               n_ts, ok_seen, ok_idx, o_FrameCount);
    end
    clear_stats();
    drive(1'b1, 1'b1, 1'b1, MAC[47:40], 0);
    idle(3);
    n_vec++;
    if (drop_seen !== 1 || drop_idx !== 0 || o_DropCause !== 3'd7 || o_DropCount !== 16'd2) begin
      n_err++;
      $display("FAIL single_byte: got %0d drops at byte %0d cause %0d count %0d, want 1 0 7 2",
               drop_seen, drop_idx, o_DropCause, o_DropCount);
    end
  endtask

  task automatic test_gaps_and_reset();
    apply_reset();
    build_frame(MAC, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b1, -1);
    idle(3);
    n_vec++;
    if (n_ts !== 1316 || n_sync !== 7 || ok_seen !== 1 || o_FrameCount !== 16'd1) begin
      n_err++;
      $display("FAIL gaps_frame: got ts %0d sync %0d ok %0d frames %0d, want 1316 7 1 1",
               n_ts, n_sync, ok_seen, o_FrameCount);
    end
    build_frame(MAC, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b0, 42 + 50);
    @(negedge clk);
    rst = 1'b1; i_Valid = 1'b0; cur_idx = -1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({o_ts_valid, o_ts_data, o_FrameCount} !== 25'd0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL mid_reset: got valid %b data %h frames %0d pending %0d, want 0 0 0 0",
               o_ts_valid, o_ts_data, o_FrameCount, exp_q.size());
    end
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    build_frame(MAC, PORT, -1, 7 * LEN, 4);
    send_frame(7 * LEN, 1'b0, -1);
    idle(3);
    n_vec++;
    if (n_ts !== 1316 || ok_seen !== 1 || o_FrameCount !== 16'd1 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL post_reset: got ts %0d ok %0d frames %0d pending %0d, want 1316 1 1 0",
               n_ts, ok_seen, o_FrameCount, exp_q.size());
    end
  endtask

  initial begin
    clear_stats();
    fork
      monitor();
    join_none
    test_reset();
    test_good_frame();
    test_bad_mac();
    test_bad_port();
    test_bad_sync();
    test_back_to_back();
    test_gaps_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
